// File: rtl/otter_intc_pkg.sv
// Shared register-map constants for the otter external interrupt controller.
package otter_intc_pkg;

    // Register byte offsets within the 32-byte MMIO window
    localparam logic [4:0] INTC_PENDING_OFF = 5'h00;
    localparam logic [4:0] INTC_ENABLE_OFF  = 5'h04;
    localparam logic [4:0] INTC_EDGE_OFF    = 5'h08;
    localparam logic [4:0] INTC_CLAIM_OFF   = 5'h0C;
    localparam logic [4:0] INTC_STATUS_OFF  = 5'h10;

    // Word index of each register (bus_addr[4:2])
    localparam logic [2:0] INTC_PENDING_IDX = INTC_PENDING_OFF[4:2];
    localparam logic [2:0] INTC_ENABLE_IDX  = INTC_ENABLE_OFF[4:2];
    localparam logic [2:0] INTC_EDGE_IDX    = INTC_EDGE_OFF[4:2];
    localparam logic [2:0] INTC_CLAIM_IDX   = INTC_CLAIM_OFF[4:2];
    localparam logic [2:0] INTC_STATUS_IDX  = INTC_STATUS_OFF[4:2];

    // Source ID meaning "no source"
    localparam logic [4:0] INTC_ID_NONE = 5'd0;

    // STATUS register fields: {26'b0, busy, claim_id[4:0]}
    localparam int unsigned INTC_STATUS_ID_LSB = 0;
    localparam int unsigned INTC_STATUS_ID_MSB = 4;
    localparam int unsigned INTC_STATUS_BUSY   = 5;

endpackage

// File: rtl/otter_intc_gateway.sv
// Per-source gateway: synchroniser, rising-edge detect and pending flop.
module otter_intc_gateway #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,         // raw asynchronous request
    input  logic edge_mode,   // 1 = edge triggered, 0 = level
    input  logic in_service,  // this source is the one currently claimed
    input  logic claim_clr,   // claim of this source in edge mode
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    logic                   s;
    logic                   rise;
    logic                   pending_d;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_prev_q;

    // Next pending state; a new edge beats a same-cycle claim
    always_comb begin
        pending_d = pending;
        if (edge_mode) begin
            if (rise) begin
                pending_d = 1'b1;
            end else if (claim_clr) begin
                pending_d = 1'b0;
            end
        end else if (!in_service) begin
            pending_d = s;
        end
    end

    // Synchroniser chain, edge history and pending state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
            pending  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], irq};
            s_prev_q <= s;
            pending  <= pending_d;
        end
    end

endmodule

// File: rtl/otter_intc.sv
// External interrupt controller: gateways, fixed-priority arbiter and MMIO
// claim/complete register window feeding ext_intrpt to the CSR unit.
module otter_intc
    import otter_intc_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               bus_sel,
    input  logic               bus_we,
    input  logic [4:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    output logic               bus_rvld,
    output logic               ext_intrpt
);

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] edge_q;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] claim_clr;
    logic [NUM_SRC-1:0] pend_en;
    logic               busy_q;
    logic [4:0]         claim_id_q;
    logic [31:0]        rdata_q;
    logic               rvld_q;
    logic               ext_q;
    logic [4:0]         winner_id;
    logic [4:0]         claim_val;
    logic [2:0]         reg_idx;
    logic               rd_strobe;
    logic               wr_strobe;
    logic               claim_rd;
    logic               complete_wr;
    logic [31:0]        rd_mux;
    logic               unused_bits;

    assign reg_idx     = bus_addr[4:2];
    assign rd_strobe   = bus_sel & ~bus_we;
    assign wr_strobe   = bus_sel & bus_we;
    assign pend_en     = pending & enable_q;
    // A claim while busy reads 0 and has no side effects
    assign claim_val   = busy_q ? INTC_ID_NONE : winner_id;
    assign claim_rd    = rd_strobe && (reg_idx == INTC_CLAIM_IDX) && (claim_val != INTC_ID_NONE);
    assign complete_wr = wr_strobe && (reg_idx == INTC_CLAIM_IDX) && busy_q &&
                         (bus_wdata[4:0] == claim_id_q);
    assign unused_bits = ^{bus_addr[1:0], bus_wdata};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign in_service[gi] = busy_q && (claim_id_q == 5'(gi + 1));
            assign claim_clr[gi]  = claim_rd && (claim_val == 5'(gi + 1)) && edge_q[gi];

            otter_intc_gateway #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_gateway (
                .clk       (clk),
                .rst_n     (rst_n),
                .irq       (src_irq[gi]),
                .edge_mode (edge_q[gi]),
                .in_service(in_service[gi]),
                .claim_clr (claim_clr[gi]),
                .pending   (pending[gi])
            );
        end
    endgenerate

    // Fixed priority: lowest pending & enabled index wins, reported as index+1
    always_comb begin
        winner_id = INTC_ID_NONE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend_en[i]) begin
                winner_id = 5'(i + 1);
            end
        end
    end

    // Read data selection
    always_comb begin
        rd_mux = '0;
        case (reg_idx)
            INTC_PENDING_IDX: rd_mux[NUM_SRC-1:0] = pending;
            INTC_ENABLE_IDX:  rd_mux[NUM_SRC-1:0] = enable_q;
            INTC_EDGE_IDX:    rd_mux[NUM_SRC-1:0] = edge_q;
            INTC_CLAIM_IDX:   rd_mux[4:0]         = claim_val;
            INTC_STATUS_IDX: begin
                rd_mux[INTC_STATUS_BUSY]                          = busy_q;
                rd_mux[INTC_STATUS_ID_MSB:INTC_STATUS_ID_LSB] = claim_id_q;
            end
            default:          rd_mux = '0;
        endcase
    end

    // Register file, claim/complete tracking, read return and request output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q   <= '0;
            edge_q     <= '0;
            busy_q     <= 1'b0;
            claim_id_q <= INTC_ID_NONE;
            rdata_q    <= '0;
            rvld_q     <= 1'b0;
            ext_q      <= 1'b0;
        end else begin
            rvld_q <= rd_strobe;
            if (rd_strobe) begin
                rdata_q <= rd_mux;
            end
            ext_q <= (|pend_en) && !busy_q;
            if (wr_strobe && (reg_idx == INTC_ENABLE_IDX)) begin
                enable_q <= bus_wdata[NUM_SRC-1:0];
            end
            if (wr_strobe && (reg_idx == INTC_EDGE_IDX)) begin
                edge_q <= bus_wdata[NUM_SRC-1:0];
            end
            if (claim_rd) begin
                busy_q     <= 1'b1;
                claim_id_q <= claim_val;
            end else if (complete_wr) begin
                busy_q     <= 1'b0;
                claim_id_q <= INTC_ID_NONE;
            end
        end
    end

    assign bus_rdata  = rdata_q;
    assign bus_rvld   = rvld_q;
    assign ext_intrpt = ext_q;

endmodule

// File: tb/tb_otter_intc.sv
// Self-checking bench for otter_intc: read scoreboard plus per-scenario checks.
module tb_otter_intc;
    import otter_intc_pkg::*;

    localparam int unsigned NUM_SRC     = 8;
    localparam int unsigned SYNC_STAGES = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_SRC-1:0] src_irq = '0;
    logic               bus_sel = 1'b0;
    logic               bus_we = 1'b0;
    logic [4:0]         bus_addr = '0;
    logic [31:0]        bus_wdata = '0;
    logic [31:0]        bus_rdata;
    logic               bus_rvld;
    logic               ext_intrpt;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    int          due_q[$];
    string       name_q[$];

    otter_intc #(
        .NUM_SRC    (NUM_SRC),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_irq   (src_irq),
        .bus_sel   (bus_sel),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_rvld  (bus_rvld),
        .ext_intrpt(ext_intrpt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every read must return its expected word exactly one cycle later
    always @(negedge clk) begin : sb
        logic [31:0] e;
        int          d;
        string       nm;
        if (rst_n) begin
            if (bus_rvld) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rvld_unexpected: bus_rvld=1 with no read outstanding (cycle %0d)",
                             cyc);
                end else begin
                    e  = exp_q.pop_front();
                    d  = due_q.pop_front();
                    nm = name_q.pop_front();
                    if (bus_rdata !== e || d != cyc) begin
                        $display("FAIL %s: rdata=0x%08h at cycle %0d, required 0x%08h at cycle %0d",
                                 nm, bus_rdata, cyc, e, d);
                    end else begin
                        n_pass++;
                    end
                end
            end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
                n_checks++;
                e  = exp_q.pop_front();
                d  = due_q.pop_front();
                nm = name_q.pop_front();
                $display("FAIL %s: bus_rvld=0 at cycle %0d, required 1 with 0x%08h", nm, cyc, e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_rd(input logic [4:0] addr, input logic [31:0] exp, input string nm);
        bus_sel  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = addr;
        exp_q.push_back(exp);
        due_q.push_back(cyc + 1);
        name_q.push_back(nm);
        @(negedge clk);
        bus_sel = 1'b0;
    endtask

    task automatic bus_wr(input logic [4:0] addr, input logic [31:0] data);
        bus_sel   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = addr;
        bus_wdata = data;
        @(negedge clk);
        bus_sel = 1'b0;
        bus_we  = 1'b0;
    endtask

    task automatic pulse_src(input logic [NUM_SRC-1:0] mask);
        src_irq = src_irq | mask;
        repeat (3) @(negedge clk);
        src_irq = src_irq & ~mask;
        repeat (SYNC_STAGES + 2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        src_irq = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus_rvld !== 1'b0 || ext_intrpt !== 1'b0 || bus_rdata !== 32'h0) begin
            $display("FAIL reset_outputs: rvld=%b ext=%b rdata=0x%08h, required 0 0 0",
                     bus_rvld, ext_intrpt, bus_rdata);
        end else begin
            n_pass++;
        end
        rst_n = 1'b1;
        bus_rd(INTC_PENDING_OFF, 32'h0, "reset_pending");
        bus_rd(INTC_ENABLE_OFF, 32'h0, "reset_enable");
        bus_rd(INTC_EDGE_OFF, 32'h0, "reset_edge");
        bus_rd(INTC_STATUS_OFF, 32'h0, "reset_status");
        bus_rd(INTC_CLAIM_OFF, 32'h0, "reset_claim");
        repeat (2) @(negedge clk);
        n_checks++;
        if (ext_intrpt !== 1'b0) begin
            $display("FAIL reset_ext: ext_intrpt=%b, required 0", ext_intrpt);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_level();
        bit seen;
        bus_wr(INTC_ENABLE_OFF, 32'h04);
        bus_wr(INTC_EDGE_OFF, 32'h00);
        src_irq[2] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < SYNC_STAGES + 2 && !seen; i++) begin
            @(negedge clk);
            seen = ext_intrpt;
        end
        n_checks++;
        if (!seen) $display("FAIL level_request: ext_intrpt=0, required 1 within %0d cycles",
                            SYNC_STAGES + 2);
        else n_pass++;
        bus_rd(INTC_CLAIM_OFF, 32'd3, "level_claim");
        bus_rd(INTC_STATUS_OFF, 32'h23, "level_status");
        n_checks++;
        if (ext_intrpt !== 1'b0) $display("FAIL level_busy_ext: ext_intrpt=%b, required 0",
                                          ext_intrpt);
        else n_pass++;
        bus_rd(INTC_PENDING_OFF, 32'h04, "level_pending_held");
        bus_wr(INTC_CLAIM_OFF, 32'd3);
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            @(negedge clk);
            seen = ext_intrpt;
        end
        n_checks++;
        if (!seen) $display("FAIL level_rerequest: ext_intrpt=0, required 1 within 2 cycles");
        else n_pass++;
        src_irq[2] = 1'b0;
        repeat (SYNC_STAGES + 4) @(negedge clk);
        n_checks++;
        if (ext_intrpt !== 1'b0) $display("FAIL level_drop: ext_intrpt=%b, required 0", ext_intrpt);
        else n_pass++;
        bus_rd(INTC_PENDING_OFF, 32'h0, "level_pending_clear");
    endtask

    task automatic test_priority();
        bus_wr(INTC_ENABLE_OFF, 32'hFF);
        bus_wr(INTC_EDGE_OFF, 32'hFF);
        pulse_src(8'b0010_0010);
        n_checks++;
        if (ext_intrpt !== 1'b1) $display("FAIL prio_request: ext_intrpt=%b, required 1", ext_intrpt);
        else n_pass++;
        bus_rd(INTC_CLAIM_OFF, 32'd2, "prio_claim_first");
        bus_rd(INTC_PENDING_OFF, 32'h20, "prio_pending_after");
        bus_rd(INTC_CLAIM_OFF, 32'd0, "prio_claim_busy");
        bus_wr(INTC_CLAIM_OFF, 32'd2);
        bus_rd(INTC_CLAIM_OFF, 32'd6, "prio_claim_second");
        bus_wr(INTC_CLAIM_OFF, 32'd6);
        bus_rd(INTC_PENDING_OFF, 32'h0, "prio_pending_empty");
    endtask

    task automatic test_complete();
        pulse_src(8'b0000_1000);
        bus_wr(INTC_ENABLE_OFF, 32'h00);
        bus_rd(INTC_PENDING_OFF, 32'h08, "cmp_pending_kept");
        repeat (2) @(negedge clk);
        n_checks++;
        if (ext_intrpt !== 1'b0) $display("FAIL cmp_disabled_ext: ext_intrpt=%b, required 0",
                                          ext_intrpt);
        else n_pass++;
        bus_wr(INTC_ENABLE_OFF, 32'hFFFF_FFFF);
        bus_rd(INTC_ENABLE_OFF, 32'hFF, "cmp_enable_width");
        bus_rd(INTC_CLAIM_OFF, 32'd4, "cmp_claim4");
        bus_wr(INTC_CLAIM_OFF, 32'd5);
        bus_rd(INTC_STATUS_OFF, 32'h24, "cmp_wrong_id");
        bus_wr(INTC_CLAIM_OFF, 32'd4);
        bus_rd(INTC_STATUS_OFF, 32'h00, "cmp_released");
        bus_rd(5'h14, 32'h0, "cmp_unmapped");
        pulse_src(8'b0100_0000);
        bus_rd(INTC_CLAIM_OFF, 32'd7, "cmp_claim7");
        bus_wr(INTC_ENABLE_OFF, 32'h00);
        bus_wr(INTC_CLAIM_OFF, 32'd7);
        bus_rd(INTC_STATUS_OFF, 32'h00, "cmp_disabled_release");
        bus_wr(INTC_ENABLE_OFF, 32'hFF);
    endtask

    task automatic test_edge_race();
        pulse_src(8'b0000_0001);
        src_irq[0] = 1'b1;
        repeat (SYNC_STAGES) @(negedge clk);
        // Claim strobe lands on the same edge that sets pending from the new rise
        bus_rd(INTC_CLAIM_OFF, 32'd1, "race_claim");
        bus_rd(INTC_PENDING_OFF, 32'h01, "race_pending_kept");
        src_irq[0] = 1'b0;
        bus_wr(INTC_CLAIM_OFF, 32'd1);
        bus_rd(INTC_CLAIM_OFF, 32'd1, "race_reclaim");
        bus_wr(INTC_CLAIM_OFF, 32'd1);
        bus_rd(INTC_PENDING_OFF, 32'h0, "race_pending_clear");
    endtask

    task automatic test_reset_mid_read();
        pulse_src(8'b0001_0000);
        bus_rd(INTC_CLAIM_OFF, 32'd5, "rst_claim5");
        bus_sel  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = INTC_STATUS_OFF;
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        bus_sel = 1'b0;
        #1;
        n_checks++;
        if (bus_rvld !== 1'b0 || bus_rdata !== 32'h0 || ext_intrpt !== 1'b0) begin
            $display("FAIL rst_async: rvld=%b rdata=0x%08h ext=%b, required 0 0 0",
                     bus_rvld, bus_rdata, ext_intrpt);
        end else begin
            n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_rd(INTC_STATUS_OFF, 32'h0, "rst_status");
        bus_rd(INTC_ENABLE_OFF, 32'h0, "rst_enable");
        bus_rd(INTC_PENDING_OFF, 32'h0, "rst_pending");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_level();
        test_priority();
        test_complete();
        test_edge_race();
        test_reset_mid_read();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_drain: %0d reads outstanding, required 0",
                                        exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/otter_intc.md
Name: otter_intc

Overview:
- Memory-mapped external interrupt controller that sits directly upstream of the CSR unit.
- Synchronises and gates up to NUM_SRC peripheral interrupt lines and arbitrates them by fixed priority.
- Drives the single ext_intrpt input that the CSR samples into mip[11].
- Software claims and completes sources through a small MMIO register window, so only one source is in service at a time.

Parameters:
NUM_SRC, 8, number of interrupt sources; legal range 1..31; source IDs are 1..NUM_SRC, ID 0 means "none".
SYNC_STAGES, 2, flip-flop synchroniser depth per source; minimum 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
src_irq  in  NUM_SRC  raw asynchronous peripheral interrupt lines, active-high
bus_sel  in  1  MMIO access strobe, one cycle per access
bus_we  in  1  1 = write, 0 = read
bus_addr  in  5  byte offset; bits [4:2] select the register, bits [1:0] are ignored
bus_wdata  in  32  write data
bus_rdata  out  32  registered read data
bus_rvld  out  1  read data valid, pulses exactly one cycle after a read strobe
ext_intrpt  out  1  interrupt request to the CSR unit

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state: all flops clear. bus_rdata=0, bus_rvld=0, ext_intrpt=0, pending=0, enable=0, edge=0, busy=0, claim_id=0, synchroniser chains=0.
- Gateway (per source i):
  - src_irq[i] passes through SYNC_STAGES flops to give s[i].
  - Edge mode (edge[i]=1): a rising edge of s[i] sets pending[i].
  - Level mode (edge[i]=0): pending[i] follows s[i] every cycle, except that it is held while source i is in service.
- Register map (offset, access):
  - 0x00 PENDING (RO): pending[NUM_SRC-1:0], zero-extended.
  - 0x04 ENABLE (RW).
  - 0x08 EDGE (RW).
  - 0x0C CLAIM/COMPLETE:
    - Read: returns the winner ID, i.e. lowest index i with pending&enable set, reported as i+1; returns 0 if there is none or busy=1.
    - Read side effects when the returned ID is nonzero: busy<=1, claim_id<=ID, and pending cleared for an edge source.
    - Write: if busy and bus_wdata[4:0]==claim_id, then busy<=0 and claim_id<=0; otherwise ignored.
  - 0x10 STATUS (RO): {26'b0, busy, claim_id[4:0]}.
  - 0x14–0x1C: read 0; writes ignored.
- Reads: bus_rdata is captured at the strobe edge and bus_rvld is 1 on the following cycle (latency 1). Back-to-back reads are legal.
- Writes: take effect at the strobe edge; bus_rvld stays 0. Bits at index NUM_SRC and above are ignored.
- ext_intrpt is registered and equals |(pending & enable) && !busy, one cycle after the qualifying state.
- Boundary conditions:
  - Edge arrives in the same cycle as the claim of that same edge source: the new edge wins and pending stays 1.
  - CLAIM read while busy: returns 0, no side effects.
  - Clearing an enable bit does not clear pending.
  - Complete for a disabled or non-pending source still releases busy if the ID matches.
  - Level source still asserted at complete: it re-pends on the next cycle and re-requests.
  - Reset asserted mid-transaction: everything clears immediately, the read is dropped, and bus_rvld=0.

Decomposition:
- otter_defines.vh gets:
  - INTC_PENDING_OFF, INTC_ENABLE_OFF, INTC_EDGE_OFF, INTC_CLAIM_OFF, INTC_STATUS_OFF
  - INTC_ID_NONE=0
  - the STATUS field positions
- One sub-module, otter_intc_gateway (synchroniser, edge detect, pending flop for one source), instantiated NUM_SRC times via generate.
- Priority encoder and register file stay in otter_intc.

Test Plan:
1. Reset, then read 0x00, 0x04, 0x08, 0x10 -> all 0x0000_0000, bus_rvld high one cycle after each strobe, ext_intrpt=0.
2. Write ENABLE=0x04 and EDGE=0x00; hold src_irq[2]=1 -> ext_intrpt=1 within SYNC_STAGES+2 cycles. CLAIM read -> 3, STATUS=0x23, ext_intrpt=0. Write 3 to 0x0C while src still high -> ext_intrpt returns to 1 within 2 cycles.
3. ENABLE=0xFF, EDGE=0xFF; pulse src_irq[5] and src_irq[1] together -> CLAIM returns 2, PENDING=0x20. Second CLAIM read returns 0 (busy). Complete 2, then CLAIM returns 6.
4. Busy with ID 4; write 5 to 0x0C -> ignored, STATUS still 0x24. Write 4 -> STATUS=0x00.
5. Edge source 0 with an edge landing on the same cycle as its claim -> claim returns 1 and PENDING bit 0 stays 1.
6. Assert rst_n=0 mid-read while busy -> bus_rvld=0, busy=0, ext_intrpt=0 immediately, without waiting for a clock edge.
